// File: rtl/v_alu_seq_pkg.sv
// Shared constants for the vector ALU sequencer: function codes, lane width
// and the sequencer state encoding.
package v_alu_pkg;

  localparam int FS_W   = 5;
  localparam int LANE_W = 8;

  localparam logic [FS_W-1:0] ADDUS  = 5'h00;
  localparam logic [FS_W-1:0] MULADD = 5'h01;
  localparam logic [FS_W-1:0] MULEI  = 5'h02;
  localparam logic [FS_W-1:0] MULOI  = 5'h03;
  localparam logic [FS_W-1:0] MRGLO  = 5'h06;
  localparam logic [FS_W-1:0] MRGHI  = 5'h07;
  localparam logic [FS_W-1:0] VPACK  = 5'h08;
  localparam logic [FS_W-1:0] VCMPE  = 5'h09;
  localparam logic [FS_W-1:0] VCLTU  = 5'h0A;
  localparam logic [FS_W-1:0] PASS_S = 5'h0B;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_LOAD_ST = 3'd2,
    ST_LOAD_C  = 3'd3,
    ST_EXEC    = 3'd4,
    ST_WB      = 3'd5
  } state_t;

  // Only MULADD needs the third operand; reserved codes fall through as non-MULADD.
  function automatic logic is_muladd(input logic [FS_W-1:0] fs);
    return fs == MULADD;
  endfunction

endpackage

// File: rtl/v_alu_seq_if.sv
// Command and writeback handshakes of the vector ALU sequencer.
interface v_alu_seq_if
  import v_alu_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 64
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [FS_W-1:0] cmd_fs;
  logic [AW-1:0]   cmd_s;
  logic [AW-1:0]   cmd_t;
  logic [AW-1:0]   cmd_c;
  logic [AW-1:0]   cmd_d;

  logic            wb_valid;
  logic            wb_ready;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;

  modport master (
    output cmd_valid, cmd_fs, cmd_s, cmd_t, cmd_c, cmd_d, wb_ready,
    input  cmd_ready, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  cmd_valid, cmd_fs, cmd_s, cmd_t, cmd_c, cmd_d, wb_ready,
    output cmd_ready, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/v_alu_seq.sv
// Vector ALU sequencer: fetches operands from the register file, feeds the
// combinational ALU from registers and retires the result with backpressure.
module v_alu_seq
  import v_alu_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 64,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  v_alu_seq_if.slave      bus,
  output logic [AW-1:0]   rf_ra_addr,
  output logic [AW-1:0]   rf_rb_addr,
  input  logic [DW-1:0]   rf_ra_data,
  input  logic [DW-1:0]   rf_rb_data,
  output logic [DW-1:0]   alu_s,
  output logic [DW-1:0]   alu_t,
  output logic [DW-1:0]   alu_c,
  output logic [FS_W-1:0] alu_fs,
  input  logic [DW-1:0]   alu_y,
  output logic            busy,
  output logic [CW-1:0]   op_count
);

  state_t        state_q, state_d;
  logic [AW-1:0] c_q, d_q;
  logic          wb_valid_q;
  logic [AW-1:0] wb_addr_q;
  logic [DW-1:0] wb_data_q;

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.wb_data   = wb_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.cmd_valid) state_d = ST_READ;
      ST_READ:    state_d = ST_LOAD_ST;
      ST_LOAD_ST: state_d = is_muladd(alu_fs) ? ST_LOAD_C : ST_EXEC;
      ST_LOAD_C:  state_d = ST_EXEC;
      ST_EXEC:    state_d = ST_WB;
      ST_WB:      if (bus.wb_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // alu_fs doubles as the latched command function for the whole operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_ra_addr <= '0;
      rf_rb_addr <= '0;
      c_q        <= '0;
      d_q        <= '0;
      alu_s      <= '0;
      alu_t      <= '0;
      alu_c      <= '0;
      alu_fs     <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      op_count   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.cmd_valid) begin
          alu_fs     <= bus.cmd_fs;
          rf_ra_addr <= bus.cmd_s;
          rf_rb_addr <= bus.cmd_t;
          c_q        <= bus.cmd_c;
          d_q        <= bus.cmd_d;
        end
        // Port A has already sampled S on this edge, so it is free for C.
        ST_READ: if (is_muladd(alu_fs)) rf_ra_addr <= c_q;
        ST_LOAD_ST: begin
          alu_s <= rf_ra_data;
          alu_t <= rf_rb_data;
          if (!is_muladd(alu_fs)) alu_c <= '0;
        end
        ST_LOAD_C: alu_c <= rf_ra_data;
        ST_EXEC: begin
          wb_data_q  <= alu_y;
          wb_addr_q  <= d_q;
          wb_valid_q <= 1'b1;
        end
        ST_WB: if (bus.wb_ready) begin
          wb_valid_q <= 1'b0;
          op_count   <= op_count + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_v_alu_seq.sv
// Bench for v_alu_seq: behavioural register file and reduced ALU, vector table
// plus directed backpressure, reset and counter-wrap sequences.
module tb_v_alu_seq;
  import v_alu_pkg::*;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  v_alu_seq_if #(.AW(AW), .DW(DW)) bus ();

  logic [AW-1:0]   rf_ra_addr, rf_rb_addr;
  logic [DW-1:0]   rf_ra_data, rf_rb_data;
  logic [DW-1:0]   alu_s, alu_t, alu_c, alu_y;
  logic [FS_W-1:0] alu_fs;
  logic            busy;
  logic [CW-1:0]   op_count;

  v_alu_seq #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .rf_ra_data (rf_ra_data),
    .rf_rb_data (rf_rb_data),
    .alu_s      (alu_s),
    .alu_t      (alu_t),
    .alu_c      (alu_c),
    .alu_fs     (alu_fs),
    .alu_y      (alu_y),
    .busy       (busy),
    .op_count   (op_count)
  );

  // Synchronous-read register file.
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) begin
    rf_ra_data <= rf_mem[rf_ra_addr];
    rf_rb_data <= rf_mem[rf_rb_addr];
  end

  // Reduced ALU: saturating add, lane multiply-add, everything else PASS_S.
  logic [8:0]  sum9;
  logic [15:0] prod;
  always_comb begin
    alu_y = alu_s;
    sum9  = '0;
    prod  = '0;
    case (alu_fs)
      ADDUS: for (int i = 0; i < 8; i++) begin
        sum9 = {1'b0, alu_s[i*LANE_W +: LANE_W]} + {1'b0, alu_t[i*LANE_W +: LANE_W]};
        alu_y[i*LANE_W +: LANE_W] = sum9[8] ? 8'hFF : sum9[7:0];
      end
      MULADD: for (int i = 0; i < 8; i++) begin
        prod = 16'(alu_s[i*LANE_W +: LANE_W]) * 16'(alu_t[i*LANE_W +: LANE_W])
             + 16'(alu_c[i*LANE_W +: LANE_W]);
        alu_y[i*LANE_W +: LANE_W] = prod[7:0];
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [FS_W-1:0] fs;
    logic [AW-1:0]   s, t, c, d;
    logic [DW-1:0]   sv, tv, cv, exp;
    int              lat;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_t;

  wb_t           sb[$];
  wb_t           mon_e;
  int            n_cmp = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Scoreboard: every retiring writeback is matched against the oldest accepted command.
  always @(negedge clk) begin
    if (reset_n && bus.wb_valid && bus.wb_ready) begin
      if (sb.size() == 0) fail("wb_unexpected");
      else begin
        mon_e = sb.pop_front();
        chk("wb_addr", 64'(bus.wb_addr), 64'(mon_e.addr));
        chk("wb_data", bus.wb_data, mon_e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [FS_W-1:0] fs, input logic [AW-1:0] s, t, c, d,
                       input logic [DW-1:0] exp);
    int n = 0;
    bus.cmd_fs = fs; bus.cmd_s = s; bus.cmd_t = t; bus.cmd_c = c; bus.cmd_d = d;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 50) begin step(); n++; end
    if (!bus.cmd_ready) fail("cmd_ready_wait");
    sb.push_back('{d, exp});
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Called in cycle 1 after the handshake; returns the cycle wb_valid rose.
  task automatic wait_wb(output int lat, input bit chk_ra, input logic [AW-1:0] ra_exp);
    lat = 1;
    while (!bus.wb_valid && lat < 30) begin
      if (lat == 2 && chk_ra) chk("ra_addr_load_st", 64'(rf_ra_addr), 64'(ra_exp));
      step();
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    rf_mem[v.c] = v.cv; rf_mem[v.s] = v.sv; rf_mem[v.t] = v.tv;
    issue(v.fs, v.s, v.t, v.c, v.d, v.exp);
    chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
    wait_wb(lat, 1'b1, is_muladd(v.fs) ? v.c : v.s);
    chk("latency", 64'(lat), 64'(v.lat));
    chk("alu_fs", 64'(alu_fs), 64'(v.fs));
    step();
    exp_cnt++;
    chk("op_count", 64'(op_count), 64'(exp_cnt));
    chk("idle_after_wb", 64'(bus.cmd_ready), 64'd1);
  endtask

  vec_t vt[7];

  initial begin
    int lat;
    logic [DW-1:0] hold_d;
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    bus.cmd_valid = 1'b0; bus.cmd_fs = '0;
    bus.cmd_s = '0; bus.cmd_t = '0; bus.cmd_c = '0; bus.cmd_d = '0;
    bus.wb_ready = 1'b1;

    vt[0] = '{ADDUS,    5'd1,  5'd2,  5'd0,  5'd3,  64'hF0, 64'h20, 64'h0, 64'hFF, 4};
    vt[1] = '{MULADD,   5'd4,  5'd5,  5'd6,  5'd7,  64'h03, 64'h04, 64'h05, 64'h11, 5};
    vt[2] = '{5'h1F,    5'd8,  5'd9,  5'd0,  5'd10, 64'h0123456789ABCDEF,
              64'hFFFF0000FFFF0000, 64'h0, 64'h0123456789ABCDEF, 4};
    vt[3] = '{ADDUS,    5'd11, 5'd12, 5'd0,  5'd13, 64'h7F80FF0001020304,
              64'h0180010010203040, 64'h0, 64'h80FFFF0011223344, 4};
    vt[4] = '{MULADD,   5'd14, 5'd15, 5'd16, 5'd17, 64'h0205, 64'h0306, 64'h0101,
              64'h071F, 5};
    vt[5] = '{PASS_S,   5'd18, 5'd19, 5'd0,  5'd20, 64'hDEADBEEFCAFEF00D, 64'h1, 64'h0,
              64'hDEADBEEFCAFEF00D, 4};
    vt[6] = '{5'h04,    5'd21, 5'd22, 5'd0,  5'd23, 64'h5A5A5A5A00000001, 64'h2, 64'h0,
              64'h5A5A5A5A00000001, 4};

    // Reset values while reset_n is held low.
    step();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_wb_data", bus.wb_data, 64'd0);
    chk("rst_alu_s", alu_s, 64'd0);
    chk("rst_ra_addr", 64'(rf_ra_addr), 64'd0);
    reset_n = 1'b1;
    step();

    foreach (vt[i]) run_vec(vt[i]);

    // Backpressure: WB holds, a competing command waits for the next IDLE cycle.
    rf_mem[24] = 64'h0101010101010101;
    rf_mem[25] = 64'h0202020202020202;
    rf_mem[26] = 64'hA5A5A5A5C3C3C3C3;
    bus.wb_ready = 1'b0;
    issue(ADDUS, 5'd24, 5'd25, 5'd0, 5'd27, 64'h0303030303030303);
    wait_wb(lat, 1'b0, '0);
    chk("bp_latency", 64'(lat), 64'd4);
    hold_d = 64'h0303030303030303;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.cmd_fs = PASS_S; bus.cmd_s = 5'd26; bus.cmd_t = 5'd26; bus.cmd_d = 5'd28;
        bus.cmd_valid = 1'b1;
      end
      step();
      chk("bp_wb_valid", 64'(bus.wb_valid), 64'd1);
      chk("bp_wb_data", bus.wb_data, hold_d);
      chk("bp_wb_addr", 64'(bus.wb_addr), 64'd27);
      chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      chk("bp_op_count", 64'(op_count), 64'(exp_cnt));
    end
    bus.wb_ready = 1'b1;
    step();
    exp_cnt++;
    chk("bp_retire_count", 64'(op_count), 64'(exp_cnt));
    chk("bp_idle_not_taken", 64'(busy), 64'd0);
    sb.push_back('{5'd28, 64'hA5A5A5A5C3C3C3C3});
    step();
    bus.cmd_valid = 1'b0;
    wait_wb(lat, 1'b0, '0);
    chk("bp_second_latency", 64'(lat), 64'd4);
    step();
    exp_cnt++;
    chk("bp_second_count", 64'(op_count), 64'(exp_cnt));

    // Reset pulse during EXEC abandons the operation.
    rf_mem[29] = 64'h10; rf_mem[30] = 64'h20;
    issue(ADDUS, 5'd29, 5'd30, 5'd0, 5'd31, 64'h30);
    step(); step();
    chk("exec_busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("mid_rst_op_count", 64'(op_count), 64'd0);
    sb.delete();
    exp_cnt = '0;
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    run_vec(vt[0]);

    // Counter wrap at 2^CW-1.
    for (int i = 0; i < 300 && exp_cnt != '1; i++) begin
      rf_mem[9] = 64'(i);
      issue(PASS_S, 5'd9, 5'd9, 5'd0, 5'd12, 64'(i));
      wait_wb(lat, 1'b0, '0);
      step();
      exp_cnt++;
    end
    chk("op_count_full", 64'(op_count), 64'(2**CW - 1));
    rf_mem[9] = 64'hFEED;
    issue(PASS_S, 5'd9, 5'd9, 5'd0, 5'd12, 64'hFEED);
    wait_wb(lat, 1'b0, '0);
    step();
    chk("op_count_wrap", 64'(op_count), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
